// File: rtl/bit_pkg.sv
// Shared constants and the collector state encoding.
package bit_pkg;
    localparam int N_BITS = 10;
    localparam int IDX_W  = 4;
    localparam logic [IDX_W-1:0] NO_ONE_IDX = 4'd15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        RESULT  = 2'd2
    } state_e;
endpackage

// File: rtl/bit_accumulator.sv
// Running statistics over accepted bits: count, first/last one, any-one and parity.
module bit_accumulator
    import bit_pkg::*;
#(
    parameter int N_BITS = bit_pkg::N_BITS,
    parameter int IDX_W  = bit_pkg::IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic             bit_is_one_i,
    input  logic [IDX_W-1:0] bit_index_i,
    output logic [IDX_W-1:0] ones_count_o,
    output logic [IDX_W-1:0] first_one_idx_o,
    output logic [IDX_W-1:0] last_one_idx_o,
    output logic             any_one_o,
    output logic             parity_o
);
    localparam logic [IDX_W-1:0] NONE_IDX = IDX_W'(NO_ONE_IDX);

    logic [IDX_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] first_q, first_d;
    logic [IDX_W-1:0] last_q,  last_d;
    logic             any_q,   any_d;
    logic             par_q,   par_d;

    always_comb begin
        count_d = count_q;
        first_d = first_q;
        last_d  = last_q;
        any_d   = any_q;
        par_d   = par_q;
        if (clear_i) begin
            count_d = '0;
            first_d = NONE_IDX;
            last_d  = NONE_IDX;
            any_d   = 1'b0;
            par_d   = 1'b0;
        end else if (en_i && bit_is_one_i) begin
            // Each index is accepted at most once per scan, so the count cannot exceed N_BITS.
            count_d = count_q + 1'b1;
            last_d  = bit_index_i;
            if (!any_q) first_d = bit_index_i;
            any_d   = 1'b1;
            par_d   = ~par_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            first_q <= NONE_IDX;
            last_q  <= NONE_IDX;
            any_q   <= 1'b0;
            par_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            first_q <= first_d;
            last_q  <= last_d;
            any_q   <= any_d;
            par_q   <= par_d;
        end
    end

    assign ones_count_o    = count_q;
    assign first_one_idx_o = first_q;
    assign last_one_idx_o  = last_q;
    assign any_one_o       = any_q;
    assign parity_o        = par_q;
endmodule

// File: rtl/bit_result_collector.sv
// Collects an in-order bit scan from an upstream checker and presents a summary with a valid/ready handshake.
module bit_result_collector
    import bit_pkg::*;
#(
    parameter int N_BITS = bit_pkg::N_BITS,
    parameter int IDX_W  = bit_pkg::IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_valid,
    input  logic [IDX_W-1:0] bit_index,
    input  logic             bit_is_one,
    input  logic             bit_done,
    input  logic             result_ready,
    output logic             result_valid,
    output logic [IDX_W-1:0] ones_count,
    output logic [IDX_W-1:0] first_one_idx,
    output logic [IDX_W-1:0] last_one_idx,
    output logic             any_one,
    output logic             parity,
    output logic             seq_error,
    output logic             busy
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BITS - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] exp_idx_q, exp_idx_d;
    logic             seq_err_q, seq_err_d;
    logic             acc_clear, acc_en;
    logic             is_match, is_hold;

    assign is_match = (bit_index == exp_idx_q);
    // A repeat of the previous index is upstream stalling, not a protocol violation.
    assign is_hold  = (exp_idx_q != '0) && (bit_index == exp_idx_q - 1'b1);

    always_comb begin
        state_d   = state_q;
        exp_idx_d = exp_idx_q;
        seq_err_d = seq_err_q;
        acc_clear = 1'b0;
        acc_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = COLLECT;
                    exp_idx_d = '0;
                    seq_err_d = 1'b0;
                    acc_clear = 1'b1;
                end
            end
            COLLECT: begin
                if (bit_valid) begin
                    if (is_match) begin
                        acc_en = 1'b1;
                        if (exp_idx_q != LAST_IDX) exp_idx_d = exp_idx_q + 1'b1;
                    end else if (!is_hold) begin
                        seq_err_d = 1'b1;
                    end
                    if (is_match && (exp_idx_q == LAST_IDX)) begin
                        state_d = RESULT;
                    end else if (bit_done) begin
                        seq_err_d = 1'b1;
                        state_d   = RESULT;
                    end
                end
            end
            RESULT: begin
                if (result_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            exp_idx_q <= '0;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            exp_idx_q <= exp_idx_d;
            seq_err_q <= seq_err_d;
        end
    end

    bit_accumulator #(
        .N_BITS (N_BITS),
        .IDX_W  (IDX_W)
    ) u_acc (
        .clk             (clk),
        .rst             (rst),
        .clear_i         (acc_clear),
        .en_i            (acc_en),
        .bit_is_one_i    (bit_is_one),
        .bit_index_i     (bit_index),
        .ones_count_o    (ones_count),
        .first_one_idx_o (first_one_idx),
        .last_one_idx_o  (last_one_idx),
        .any_one_o       (any_one),
        .parity_o        (parity)
    );

    assign result_valid = (state_q == RESULT);
    assign busy         = (state_q != IDLE);
    assign seq_error    = seq_err_q;
endmodule

// File: tb/tb_bit_result_collector.sv
// Directed bench for bit_result_collector with hand-computed expected results.
module tb_bit_result_collector;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       bit_valid = 1'b0;
    logic [3:0] bit_index = 4'd0;
    logic       bit_is_one = 1'b0;
    logic       bit_done = 1'b0;
    logic       result_ready = 1'b0;
    logic       result_valid;
    logic [3:0] ones_count;
    logic [3:0] first_one_idx;
    logic [3:0] last_one_idx;
    logic       any_one;
    logic       parity;
    logic       seq_error;
    logic       busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bit_result_collector dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .bit_valid     (bit_valid),
        .bit_index     (bit_index),
        .bit_is_one    (bit_is_one),
        .bit_done      (bit_done),
        .result_ready  (result_ready),
        .result_valid  (result_valid),
        .ones_count    (ones_count),
        .first_one_idx (first_one_idx),
        .last_one_idx  (last_one_idx),
        .any_one       (any_one),
        .parity        (parity),
        .seq_error     (seq_error),
        .busy          (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_result(input string tag, input logic [3:0] cnt, input logic [3:0] fst,
                              input logic [3:0] lst, input logic any, input logic par, input logic err);
        chk({tag, ".ones_count"}, 32'(ones_count), 32'(cnt));
        chk({tag, ".first"},      32'(first_one_idx), 32'(fst));
        chk({tag, ".last"},       32'(last_one_idx), 32'(lst));
        chk({tag, ".any_one"},    32'(any_one), 32'(any));
        chk({tag, ".parity"},     32'(parity), 32'(par));
        chk({tag, ".seq_error"},  32'(seq_error), 32'(err));
    endtask

    task automatic sample(input int idx, input logic one, input logic done);
        bit_valid  = 1'b1;
        bit_index  = 4'(idx);
        bit_is_one = one;
        bit_done   = done;
        step();
    endtask

    task automatic begin_scan();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_scan(input logic [9:0] v);
        begin_scan();
        for (int i = 0; i < 10; i++) sample(i, v[i], i == 9);
        bit_valid = 1'b0;
        bit_done  = 1'b0;
    endtask

    task automatic deliver(input string tag);
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        chk({tag, ".idle_valid"}, 32'(result_valid), 32'd0);
        chk({tag, ".idle_busy"},  32'(busy), 32'd0);
    endtask

    initial begin
        // Reset state
        step();
        chk("rst.valid", 32'(result_valid), 32'd0);
        chk("rst.busy",  32'(busy), 32'd0);
        chk_result("rst", 4'd0, 4'd15, 4'd15, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step();

        // Nominal scan of 10'b10_0010_0100
        begin_scan();
        chk("s1.busy_collect", 32'(busy), 32'd1);
        for (int i = 0; i < 9; i++) sample(i, (i == 2) || (i == 5), 1'b0);
        chk("s1.valid_before_last", 32'(result_valid), 32'd0);
        sample(9, 1'b1, 1'b1);
        bit_valid = 1'b0; bit_done = 1'b0;
        chk("s1.valid", 32'(result_valid), 32'd1);
        chk_result("s1", 4'd3, 4'd2, 4'd9, 1'b1, 1'b1, 1'b0);
        deliver("s1");
        chk_result("s1.idle_hold", 4'd3, 4'd2, 4'd9, 1'b1, 1'b1, 1'b0);

        // All-zero vector
        run_scan(10'b00_0000_0000);
        chk("s2.valid", 32'(result_valid), 32'd1);
        chk_result("s2", 4'd0, 4'd15, 4'd15, 1'b0, 1'b0, 1'b0);
        deliver("s2");

        // Upstream holds index 9 with bit_done for 5 cycles
        begin_scan();
        for (int i = 0; i < 9; i++) sample(i, i == 0, 1'b0);
        sample(9, 1'b1, 1'b1);
        chk("s3.valid_first", 32'(result_valid), 32'd1);
        for (int k = 0; k < 4; k++) begin
            sample(9, 1'b1, 1'b1);
            chk($sformatf("s3.hold%0d.count", k), 32'(ones_count), 32'd2);
        end
        bit_valid = 1'b0; bit_done = 1'b0;
        chk_result("s3", 4'd2, 4'd0, 4'd9, 1'b1, 1'b0, 1'b0);
        deliver("s3");

        // Held index ignored, out-of-order index 3 flagged and not accumulated
        begin_scan();
        sample(0, 1'b1, 1'b0);
        sample(1, 1'b1, 1'b0);
        sample(1, 1'b1, 1'b0);
        chk("s4.hold_no_err", 32'(seq_error), 32'd0);
        sample(3, 1'b1, 1'b0);
        chk("s4.skip_err", 32'(seq_error), 32'd1);
        for (int i = 2; i < 10; i++) sample(i, 1'b0, i == 9);
        bit_valid = 1'b0; bit_done = 1'b0;
        chk("s4.valid", 32'(result_valid), 32'd1);
        chk_result("s4", 4'd2, 4'd0, 4'd1, 1'b1, 1'b0, 1'b1);
        deliver("s4");

        // Early bit_done after index 4
        begin_scan();
        for (int i = 0; i < 5; i++) sample(i, i == 4, i == 4);
        bit_valid = 1'b0; bit_done = 1'b0;
        chk("s5.valid", 32'(result_valid), 32'd1);
        chk_result("s5", 4'd1, 4'd4, 4'd4, 1'b1, 1'b1, 1'b1);
        deliver("s5");

        // Backpressure in RESULT with start pulses; start also pulsed mid-collect
        begin_scan();
        for (int i = 0; i < 10; i++) begin
            start = (i == 5);
            sample(i, i == 3, i == 9);
        end
        start = 1'b0; bit_valid = 1'b0; bit_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            start = k[0];
            step();
            chk($sformatf("s6.wait%0d.valid", k), 32'(result_valid), 32'd1);
            chk_result($sformatf("s6.wait%0d", k), 4'd1, 4'd3, 4'd3, 1'b1, 1'b1, 1'b0);
        end
        start = 1'b0;
        deliver("s6");
        chk_result("s6.idle_hold", 4'd1, 4'd3, 4'd3, 1'b1, 1'b1, 1'b0);

        // Asynchronous reset mid-collect, then a full scan
        begin_scan();
        for (int i = 0; i < 5; i++) sample(i, (i == 1) || (i == 4), 1'b0);
        bit_valid = 1'b0;
        chk("s7.pre_rst_count", 32'(ones_count), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("s7.rst_busy",  32'(busy), 32'd0);
        chk("s7.rst_valid", 32'(result_valid), 32'd0);
        chk_result("s7.rst", 4'd0, 4'd15, 4'd15, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        step();
        run_scan(10'b11_1111_1111);
        chk("s7.valid", 32'(result_valid), 32'd1);
        chk_result("s7", 4'd10, 4'd0, 4'd9, 1'b1, 1'b0, 1'b0);
        deliver("s7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bit_result_collector.md
BIT_RESULT_COLLECTOR -- requirements
Module: bit_result_collector

Interface
REQ-001 The parameter N_BITS SHALL default to 10 and sets the number of bit positions per scan.
REQ-002 The parameter IDX_W SHALL default to 4 and sets the width of every index port.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  begins a new collection; honoured only in IDLE.
REQ-006 bit_valid  input  1  bit_index, bit_is_one and bit_done are meaningful this cycle.
REQ-007 bit_index  input  IDX_W  index of the bit being reported by the upstream checker.
REQ-008 bit_is_one  input  1  reported bit value.
REQ-009 bit_done  input  1  upstream signals that its scan is complete.
REQ-010 result_ready  input  1  consumer accepts the result.
REQ-011 result_valid  output  1  result fields are valid and stable.
REQ-012 ones_count  output  IDX_W  number of accepted bits equal to 1.
REQ-013 first_one_idx  output  IDX_W  lowest index seen with value 1, else NO_ONE_IDX (15).
REQ-014 last_one_idx  output  IDX_W  highest index seen with value 1, else NO_ONE_IDX.
REQ-015 any_one  output  1  at least one accepted bit was 1.
REQ-016 parity  output  1  XOR of all accepted bit values.
REQ-017 seq_error  output  1  the scan was malformed; meaningful while result_valid is high.
REQ-018 busy  output  1  high in COLLECT and RESULT.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, COLLECT and RESULT.
REQ-020 IDLE->COLLECT on start; accumulators clear to reset values and expected_idx is set to 0 on the same edge.
REQ-021 In COLLECT, a sample is accepted when bit_valid=1 and bit_index==expected_idx; acceptance increments expected_idx.
REQ-022 On an accepted sample with bit_is_one=1: ones_count+1, last_one_idx=bit_index, and first_one_idx=bit_index if no 1 was seen yet; parity toggles and any_one sets.
REQ-023 A sample with bit_valid=1 and bit_index==expected_idx-1 (upstream holding its index) SHALL be ignored silently, with no accumulation and no error.
REQ-024 Any other bit_index with bit_valid=1 SHALL set seq_error and SHALL NOT be accumulated; collection continues.
REQ-025 COLLECT->RESULT on the edge that accepts index N_BITS-1; result_valid rises one cycle after that sample.
REQ-026 bit_valid=1 with bit_done=1 before index N_BITS-1 is accepted SHALL set seq_error and force COLLECT->RESULT.
REQ-027 In RESULT, all result outputs SHALL hold stable until the cycle in which result_valid and result_ready are both 1; RESULT->IDLE follows on that edge.
REQ-028 start SHALL be ignored in COLLECT and in RESULT, and SHALL have no effect on any accumulator.
REQ-029 In IDLE, result fields SHALL hold the last delivered result, and result_valid SHALL be 0.
REQ-030 ones_count SHALL never exceed N_BITS, so no wrap-around is possible; expected_idx SHALL saturate at N_BITS-1.

Reset
REQ-031 rst SHALL force IDLE immediately, from any state, including mid-COLLECT or mid-RESULT.
REQ-032 Reset values SHALL be: result_valid 0, busy 0, ones_count 0, first_one_idx 15, last_one_idx 15, any_one 0, parity 0, seq_error 0, expected_idx 0.

Structure
REQ-033 Package bit_pkg SHALL hold N_BITS, IDX_W, NO_ONE_IDX and the state enum typedef.
REQ-034 The accumulator datapath (count, first/last, parity) SHALL be one sub-module, bit_accumulator, with clear and enable inputs; the FSM and the handshake stay in the top module.

Verification
REQ-035 Stream indices 0..9 of vector 10'b10_0010_0100, one per cycle -> result_valid, ones_count 3, first 2, last 9, parity 1, any_one 1, seq_error 0.
REQ-036 All-zero vector -> ones_count 0, first 15, last 15, any_one 0, parity 0.
REQ-037 Upstream holds index 9 with bit_done=1 for 5 cycles -> index 9 is counted exactly once, and result_valid rises one cycle after its first appearance.
REQ-038 Index 3 is presented while expected_idx is 2 -> seq_error 1; the index-3 sample is not accumulated.
REQ-039 result_ready held low for 4 cycles in RESULT -> all outputs stable; IDLE is entered on the edge after ready=1, and start pulses during RESULT are ignored.
REQ-040 rst asserted after index 4 is accepted -> all REQ-032 values take effect immediately; a following start and a full scan complete correctly.
